// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered display data,
// leading-zero suppression, per-slot brightness PWM and ghosting guard.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 8192,
    parameter int unsigned DUTY_W   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   Data,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     BlankMask,
    input  logic                  LZS,
    input  logic [DUTY_W-1:0]     Brightness,
    input  logic                  Load,
    output logic [DIGITS-1:0]     Anode,
    output logic [6:0]            Segment,
    output logic                  DPOut,
    output logic                  FrameDone
);

    localparam int unsigned CNT_W = $clog2(PRESCALE);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DUTY_W-1:0]   ph_q, ph_d;

    logic [4*DIGITS-1:0] pnd_data_q, pnd_data_d, shd_data_q, shd_data_d;
    logic [DIGITS-1:0]   pnd_dp_q, pnd_dp_d, shd_dp_q, shd_dp_d;
    logic [DIGITS-1:0]   pnd_blank_q, pnd_blank_d, shd_blank_q, shd_blank_d;
    logic                pnd_lzs_q, pnd_lzs_d, shd_lzs_q, shd_lzs_d;
    logic                pnd_vld_q, pnd_vld_d;

    logic [DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic                dpout_q, dpout_d;
    logic                frame_done_q, frame_done_d;

    logic                tick, boundary;
    logic [3:0]          nib;
    logic                cur_dp, cur_blank, lz_cur, zero_run, blank_cur, duty_on;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Slot timing, pending/shadow buffering and registered pin values
    always_comb begin
        tick     = (cnt_q == CNT_W'(PRESCALE - 1));
        boundary = tick && (idx_q == IDX_W'(DIGITS - 1));
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + IDX_W'(1);
        end
        ph_d = ph_q + DUTY_W'(1);

        pnd_data_d  = pnd_data_q;
        pnd_dp_d    = pnd_dp_q;
        pnd_blank_d = pnd_blank_q;
        pnd_lzs_d   = pnd_lzs_q;
        pnd_vld_d   = pnd_vld_q;
        shd_data_d  = shd_data_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        shd_lzs_d   = shd_lzs_q;
        if (Load) begin
            pnd_data_d  = Data;
            pnd_dp_d    = DP;
            pnd_blank_d = BlankMask;
            pnd_lzs_d   = LZS;
            pnd_vld_d   = 1'b1;
        end
        // A Load landing on the boundary tick bypasses pending and commits now
        if (boundary) begin
            if (Load) begin
                shd_data_d  = Data;
                shd_dp_d    = DP;
                shd_blank_d = BlankMask;
                shd_lzs_d   = LZS;
            end else if (pnd_vld_q) begin
                shd_data_d  = pnd_data_q;
                shd_dp_d    = pnd_dp_q;
                shd_blank_d = pnd_blank_q;
                shd_lzs_d   = pnd_lzs_q;
            end
            pnd_vld_d = 1'b0;
        end

        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        lz_cur    = 1'b0;
        zero_run  = 1'b1;
        // Walk from the top digit down so zero_run means "this and all higher are 0"
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (shd_data_q[4*i +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                nib       = shd_data_q[4*i +: 4];
                cur_dp    = shd_dp_q[i];
                cur_blank = shd_blank_q[i];
                lz_cur    = zero_run && (i != 0);
            end
        end
        blank_cur = cur_blank || (shd_lzs_q && lz_cur);
        duty_on   = (Brightness == {DUTY_W{1'b1}}) || (ph_q < Brightness);

        anode_d = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!blank_cur && duty_on && (cnt_q != '0) && (idx_q == IDX_W'(i))) begin
                anode_d[i] = 1'b0;
            end
        end
        seg_d        = blank_cur ? 7'b1111111 : hex7(nib);
        dpout_d      = blank_cur ? 1'b1 : ~cur_dp;
        frame_done_d = boundary;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            ph_q         <= '0;
            pnd_data_q   <= '0;
            pnd_dp_q     <= '0;
            pnd_blank_q  <= '0;
            pnd_lzs_q    <= 1'b0;
            pnd_vld_q    <= 1'b0;
            shd_data_q   <= '0;
            shd_dp_q     <= '0;
            shd_blank_q  <= '0;
            shd_lzs_q    <= 1'b0;
            anode_q      <= '1;
            seg_q        <= 7'b1111111;
            dpout_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            ph_q         <= ph_d;
            pnd_data_q   <= pnd_data_d;
            pnd_dp_q     <= pnd_dp_d;
            pnd_blank_q  <= pnd_blank_d;
            pnd_lzs_q    <= pnd_lzs_d;
            pnd_vld_q    <= pnd_vld_d;
            shd_data_q   <= shd_data_d;
            shd_dp_q     <= shd_dp_d;
            shd_blank_q  <= shd_blank_d;
            shd_lzs_q    <= shd_lzs_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dpout_q      <= dpout_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Anode     = anode_q;
    assign Segment   = seg_q;
    assign DPOut     = dpout_q;
    assign FrameDone = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter PRESCALE, default 8192: CLK cycles per digit slot, legal range ≥ 4.
REQ-003 SHALL have parameter DUTY_W, default 4: width of the brightness control.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all logic on posedge CLK.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Data, input, 4*DIGITS bits: hex nibble per digit; nibble i = Data[4i+3:4i]; digit 0 is rightmost.
REQ-007 SHALL have port DP, input, DIGITS bits: decimal point per digit, 1 = lit.
REQ-008 SHALL have port BlankMask, input, DIGITS bits: 1 = digit forced dark.
REQ-009 SHALL have port LZS, input, 1 bit: leading-zero suppression enable.
REQ-010 SHALL have port Brightness, input, DUTY_W bits: on-time duty per slot.
REQ-011 SHALL have port Load, input, 1 bit: single-cycle request to capture Data, DP, BlankMask and LZS.
REQ-012 SHALL have port Anode, output, DIGITS bits: active-low digit enables.
REQ-013 SHALL have port Segment, output, 7 bits: active-low segments, bit0 = a … bit6 = g.
REQ-014 SHALL have port DPOut, output, 1 bit: active-low decimal point.
REQ-015 SHALL have port FrameDone, output, 1 bit: one-cycle pulse per completed scan frame.

Function
REQ-016 SHALL count a prescaler cnt 0..PRESCALE-1, wrapping to 0; slot tick = (cnt == PRESCALE-1).
REQ-017 SHALL advance digit index idx on each tick, 0→1→…→DIGITS-1→0.
REQ-018 SHALL treat the tick with idx == DIGITS-1 as the frame boundary and pulse FrameDone high in the following cycle only.
REQ-019 SHALL hold Load-captured inputs in a pending register; the last Load before a boundary wins.
REQ-020 SHALL copy pending to the active shadow at the frame boundary, so a display change is never visible mid-frame.
REQ-021 SHALL commit inputs presented with a Load that coincides with the boundary tick at that same boundary.
REQ-022 SHALL leave the shadow unchanged at a boundary with no Load since the previous boundary.
REQ-023 SHALL decode shadow nibbles as hex, using gfedcba active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 SHALL, with LZS=1, blank digit k (k ≥ 1) when nibble k and every higher nibble are 0; digit 0 is never suppressed.
REQ-025 SHALL keep a blanked digit's (mask or LZS) Anode bit high and drive Segment = 1111111 and DPOut = 1 during its slot.
REQ-026 SHALL keep a free-running DUTY_W-bit counter ph and assert the slot anode only when ph < Brightness, or always when Brightness is all ones.
REQ-027 SHALL blank every anode for the whole frame when Brightness = 0.
REQ-028 SHALL deassert all Anode bits during the first cycle of each slot (cnt == 0) for ghosting suppression.
REQ-029 SHALL register all outputs, with one-cycle latency from idx/cnt/ph to pins.
REQ-030 SHALL never drive more than one Anode bit low in any cycle.

Reset
REQ-031 SHALL, with RST high at a posedge, clear cnt, idx, ph, pending, shadow, pending-flag and FrameDone to 0.
REQ-032 SHALL, with RST high at a posedge, set Anode to all ones, Segment to 1111111 and DPOut to 1.
REQ-033 SHALL give RST priority over Load and tick, and abort any pending Load; scan restarts at digit 0 the cycle after RST falls.

Verification
REQ-034 SHALL cover basic scan (DIGITS=4, PRESCALE=4, Brightness=F, Load 0x1234 after reset): after the next boundary, slots show Anode 1110/4(0011001), 1101/3, 1011/2, 0111/1, with each anode low on cnt 1..3 only.
REQ-035 SHALL cover leading-zero suppression (Load Data=0x0005, LZS=1): digits 3..1 stay dark, digit 0 shows 0010010; with LZS=0 the zeros show 1000000.
REQ-036 SHALL cover double buffering: Load 0xAAAA mid-frame, then 0xBBBB in the same frame → the remainder of the frame shows the old value, and the next frame shows only B (0000011).
REQ-037 SHALL cover brightness: Brightness=4 → the active anode is low exactly on cycles where ph < 4 (4 of 16), and Brightness=0 keeps Anode = 1111 throughout.
REQ-038 SHALL cover mid-frame reset (RST pulsed during slot 2): Anode = 1111 and Segment = 1111111 the next cycle, shadow = 0, and FrameDone is not pulsed until a full new frame completes.
REQ-039 SHALL cover boundary Load (Load coincident with the idx=3 tick): the new value is displayed from the very next slot 0, and FrameDone is high for exactly one cycle.
